// File: rtl/lector_banco.sv
// Sequential read-out engine for the register bank.
// On an accepted start it walks base..base+count-1 (mod NREG), fetching two
// registers per bank access through RA1/RA2, and streams each word out over a
// valid/ready interface. It never writes the bank.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start with a non-zero count
// S_FETCH | RA1/RA2 stable, bank data captured at the end of the cycle
// S_SEND0 | presenting the word read through RA1
// S_SEND1 | presenting the word read through RA2
// S_FIN   | one-cycle done pulse, then back to idle
module lector_banco #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic [AW-1:0] RA1,
  output logic [AW-1:0] RA2,
  input  logic [DW-1:0] DR1,
  input  logic [DW-1:0] DR2,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND0,
    S_SEND1,
    S_FIN
  } state_t;

  // Addresses wrap modulo NREG; NREG is a power of two so a mask suffices.
  localparam logic [AW-1:0] ADDR_MASK = AW'(NREG - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_TWO  = AW'(2);
  localparam logic [AW-1:0] ADDR_TRI  = AW'(3);
  localparam logic [AW:0]   REM_ONE   = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [AW:0]   rem;
  logic [DW-1:0] buf0, buf1;
  logic [AW-1:0] addr0, addr1;

  logic accept;
  logic hs;
  logic last_word;

  assign accept    = (state == S_IDLE) && start && (count != '0);
  assign hs        = out_valid && out_ready;
  assign last_word = (rem == REM_ONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_SEND0;
      S_SEND0: if (hs) state_nxt = last_word ? S_FIN : S_SEND1;
      S_SEND1: if (hs) state_nxt = last_word ? S_FIN : S_FETCH;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pointer, remaining-word down-counter, bank addresses and word buffers.
  // RA1/RA2 move only on the edge that enters FETCH, so the bank data is
  // settled for the whole FETCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      rem   <= '0;
      RA1   <= '0;
      RA2   <= '0;
      buf0  <= '0;
      buf1  <= '0;
      addr0 <= '0;
      addr1 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ptr <= base;
            rem <= count;
            RA1 <= base;
            RA2 <= (base + ADDR_ONE) & ADDR_MASK;
          end
        end
        S_FETCH: begin
          buf0  <= DR1;
          buf1  <= DR2;
          addr0 <= RA1;
          addr1 <= RA2;
        end
        S_SEND0: begin
          if (hs) rem <= rem - REM_ONE;
        end
        S_SEND1: begin
          if (hs) begin
            rem <= rem - REM_ONE;
            ptr <= (ptr + ADDR_TWO) & ADDR_MASK;
            if (!last_word) begin
              RA1 <= (ptr + ADDR_TWO) & ADDR_MASK;
              RA2 <= (ptr + ADDR_TRI) & ADDR_MASK;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage decoded from state; the buffers hold across stalls, so the
  // presented word stays stable until it is accepted.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    out_last  = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    case (state)
      S_SEND0: begin
        out_valid = 1'b1;
        out_data  = buf0;
        out_addr  = addr0;
        out_last  = last_word;
      end
      S_SEND1: begin
        out_valid = 1'b1;
        out_data  = buf1;
        out_addr  = addr1;
        out_last  = last_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lector_banco.sv
// Scoreboard bench for lector_banco: stimulus pushes expected words, a
// monitor pops and compares on every accepted word.
module tb_lector_banco;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] RA1, RA2;
  logic [DW-1:0] DR1, DR2;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last, out_valid, busy, done;
  logic          out_ready = 1'b1;

  logic [DW-1:0] bank [N];
  assign DR1 = bank[RA1];
  assign DR2 = bank[RA2];

  lector_banco #(.NREG(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .RA1(RA1), .RA2(RA2), .DR1(DR1), .DR2(DR2),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t          exp_q[$];
  logic [2*AW-1:0] ra_log[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_cyc = -10;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // out_ready pattern: 0 = always ready, 1 = toggle, 2 = random stalls
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pop, stall stability, done timing, FETCH address log.
  logic  held = 1'b0;
  word_t hold_w;
  word_t mon_w;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_word", 64'({out_addr, out_data, out_last}), 64'(hold_w));
        end
        if (busy && !out_valid && !done) ra_log.push_back({RA1, RA2});
        if (done) begin
          done_cnt++;
          check("done_after_last", 64'(cyc), 64'(last_cyc + 1));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got addr %0d data %0h, want none", out_addr, out_data);
          end else begin
            mon_w = exp_q.pop_front();
            check("word_addr", 64'(out_addr), 64'(mon_w.addr));
            check("word_data", 64'(out_data), 64'(mon_w.data));
            check("word_last", 64'(out_last), 64'(mon_w.last));
          end
          if (out_last) last_cyc = cyc;
          held = 1'b0;
        end else if (out_valid) begin
          held   = 1'b1;
          hold_w = {out_addr, out_data, out_last};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input int b, input int c);
    word_t w;
    int a;
    for (int i = 0; i < c; i++) begin
      a      = (b + i) % N;
      w.addr = a[AW-1:0];
      w.data = bank[a];
      w.last = (i == c - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic run_dump(input int b, input int c, input bit inject, input bit chk_lat);
    int  d0;
    bit  got;
    bit  fin;
    push_exp(b, c);
    d0 = done_cnt;
    ra_log.delete();
    @(posedge clk); #1;
    start = 1'b1;
    base  = b[AW-1:0];
    count = c[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_lat) check("lat_fetch", 64'({busy, out_valid}), 64'b10);
    @(posedge clk); #1;
    if (chk_lat) check("lat_first_valid", 64'(out_valid), 64'd1);
    got = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (inject && k == 2) begin
        start = 1'b1;
        base  = 5'd9;
        count = 6'd1;
      end
      if (inject && k == 3) start = 1'b0;
      if (done) got = 1'b1;
      else if (got && !busy) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: base %0d count %0d got no completion, want done", b, c);
    end
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("all_words_out", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int  d0;
    bit  hit;
    for (int i = 0; i < N; i++) bank[i] = 32'(i * 3);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({out_valid, out_last, busy, done}), 64'd0);
    check("rst_ra", 64'({RA1, RA2}), 64'd0);
    check("rst_out", 64'({out_data, out_addr}), 64'd0);
    #2 rst_n = 1'b1;

    // basic dump with latency
    rdy_mode = 0;
    run_dump(0, 4, 1'b0, 1'b1);

    // odd count with wrap, second FETCH addresses
    run_dump(30, 3, 1'b0, 1'b0);
    check("wrap_fetches", 64'(ra_log.size()), 64'd2);
    if (ra_log.size() > 1) check("wrap_ra_fetch2", 64'(ra_log[1]), 64'({5'd0, 5'd1}));

    // backpressure
    rdy_mode = 1;
    run_dump(0, 4, 1'b0, 1'b0);
    rdy_mode = 2;
    run_dump(0, 4, 1'b0, 1'b0);
    run_dump(13, 7, 1'b0, 1'b0);

    // full bank
    rdy_mode = 0;
    run_dump(5, 32, 1'b0, 1'b0);
    rdy_mode = 2;
    run_dump(20, 32, 1'b0, 1'b0);
    rdy_mode = 0;

    // count=0 start ignored
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base = 5'd3; count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("zero_count_busy", 64'(busy), 64'd0);
    end
    check("zero_count_done", 64'(done_cnt - d0), 64'd0);

    // start mid-dump ignored
    run_dump(2, 5, 1'b1, 1'b0);

    // reset while in SEND1
    push_exp(0, 6);
    @(posedge clk); #1;
    start = 1'b1; base = '0; count = 6'd6;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid && out_addr == 5'd1) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_send1", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_busy", 64'({out_valid, busy}), 64'd0);
    check("midrst_ra", 64'({RA1, RA2}), 64'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    check("midrst_done", 64'(done) | 64'(done_cnt - d0), 64'd0);
    #2 rst_n = 1'b1;
    run_dump(0, 6, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
